// File: rtl/svi_sdram_arbiter.sv
// svi_sdram_arbiter
//   Four-port arbiter in front of a simple SDRAM controller. One access at a
//   time: a port is granted from IDLE and its command is latched. The strobe
//   is held for ACC_CYCLES cycles in ACCESS, and the port then gets a
//   one-cycle ack in ACK.
//   Priority is 0 > 1 > 2 > 3. Port 3 (cassette) is only eligible inside a
//   CPU refresh window, and it wins over port 2 right after a port-2 grant.
//
// Ports
//   clk_i, reset_n_i      clock, asynchronous active-low reset
//   req_i/we_i [3:0]      per-port request and write qualifier
//   addr_i  [4*AW-1:0]    per-port address, port n at [n*AW +: AW]
//   wdata_i [31:0]        per-port write byte, port n at [n*8 +: 8]
//   rfsh_win_i            CPU refresh window (gates port 3)
//   ack_o   [3:0]         one-cycle completion pulse for the served port
//   rdata_o [7:0]         last read data, updated only by reads
//   busy_o, grant_o       access in progress / current or last served port
//   sd_*                  SDRAM controller side
module svi_sdram_arbiter #(
  parameter int unsigned ACC_CYCLES = 8,
  parameter int unsigned AW         = 23
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic [3:0]      req_i,
  input  logic [3:0]      we_i,
  input  logic [4*AW-1:0] addr_i,
  input  logic [31:0]     wdata_i,
  input  logic            rfsh_win_i,
  output logic [3:0]      ack_o,
  output logic [7:0]      rdata_o,
  output logic            busy_o,
  output logic [1:0]      grant_o,
  input  logic            sd_ready_i,
  output logic [AW-1:0]   sd_addr_o,
  output logic [7:0]      sd_din_o,
  output logic            sd_we_o,
  output logic            sd_rd_o,
  input  logic [7:0]      sd_dout_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_ACK
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(ACC_CYCLES - 1);

  state_t          state_q, state_d;
  logic [1:0]      grant_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [7:0]      din_q;
  logic [7:0]      rdata_q;
  logic [7:0]      cnt_q;

  logic [3:0]      elig;
  logic            start;
  logic [1:0]      sel;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [7:0]      sel_din;

  assign elig  = {req_i[3] & rfsh_win_i, req_i[2:0]};
  assign start = (state_q == S_IDLE) && sd_ready_i && (elig != 4'b0000);

  // Port 3 is only promoted past port 2 when port 2 was the last one served,
  // so a continuously requesting CPU cannot starve the cassette reader.
  always_comb begin
    sel = 2'd0;
    if (elig[0])                          sel = 2'd0;
    else if (elig[1])                     sel = 2'd1;
    else if (elig[3] && grant_q == 2'd2)  sel = 2'd3;
    else if (elig[2])                     sel = 2'd2;
    else if (elig[3])                     sel = 2'd3;
  end

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    for (int unsigned n = 0; n < 4; n++) begin
      if (sel == 2'(n)) begin
        sel_we   = we_i[n];
        sel_addr = addr_i[n*AW +: AW];
        sel_din  = wdata_i[n*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_ACCESS;
      S_ACCESS: if (cnt_q == 8'd0) state_d = S_ACK;
      S_ACK:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        grant_q <= sel;
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        din_q   <= sel_din;
        cnt_q   <= CNT_LOAD;
      end else if (state_q == S_ACCESS) begin
        if (cnt_q != 8'd0) begin
          cnt_q <= cnt_q - 8'd1;
        end else if (!we_q) begin
          rdata_q <= sd_dout_i;
        end
      end
    end
  end

  // Outputs decode straight from registers, so reset clears them without
  // waiting for a clock edge.
  assign busy_o    = (state_q != S_IDLE);
  assign sd_we_o   = (state_q == S_ACCESS) &&  we_q;
  assign sd_rd_o   = (state_q == S_ACCESS) && !we_q;
  assign ack_o     = (state_q == S_ACK) ? (4'b0001 << grant_q) : 4'b0000;
  assign grant_o   = grant_q;
  assign sd_addr_o = addr_q;
  assign sd_din_o  = din_q;
  assign rdata_o   = rdata_q;

endmodule

// File: tb/tb_svi_sdram_arbiter.sv
// Testbench for svi_sdram_arbiter: a transaction-level reference model,
// checked against the DUT on every falling edge, plus directed scenarios
// with hand-computed literal expectations.
module tb_svi_sdram_arbiter;

  localparam int ACC = 8;
  localparam int AW  = 23;

  logic            clk_i = 1'b0;
  logic            reset_n_i;
  logic [3:0]      req_i;
  logic [3:0]      we_i;
  logic [4*AW-1:0] addr_i;
  logic [31:0]     wdata_i;
  logic            rfsh_win_i;
  logic [3:0]      ack_o;
  logic [7:0]      rdata_o;
  logic            busy_o;
  logic [1:0]      grant_o;
  logic            sd_ready_i;
  logic [AW-1:0]   sd_addr_o;
  logic [7:0]      sd_din_o;
  logic            sd_we_o;
  logic            sd_rd_o;
  logic [7:0]      sd_dout_i;

  svi_sdram_arbiter #(.ACC_CYCLES(ACC), .AW(AW)) dut (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .req_i      (req_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .rfsh_win_i (rfsh_win_i),
    .ack_o      (ack_o),
    .rdata_o    (rdata_o),
    .busy_o     (busy_o),
    .grant_o    (grant_o),
    .sd_ready_i (sd_ready_i),
    .sd_addr_o  (sd_addr_o),
    .sd_din_o   (sd_din_o),
    .sd_we_o    (sd_we_o),
    .sd_rd_o    (sd_rd_o),
    .sd_dout_i  (sd_dout_i)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: m_t counts cycles since the grant edge (0 = idle).
  // Cycles 1..ACC are the access, cycle ACC+1 is the ack.
  int            m_t;
  int            m_port;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_din;
  logic [7:0]    m_rdata;

  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      m_t = 0; m_port = 0; m_we = 0; m_addr = '0; m_din = '0; m_rdata = '0;
    end else if (m_t == 0) begin
      int p;
      p = -1;
      if (sd_ready_i) begin
        if (req_i[0])                                    p = 0;
        else if (req_i[1])                               p = 1;
        else if (m_port == 2 && req_i[3] && rfsh_win_i)  p = 3;
        else if (req_i[2])                               p = 2;
        else if (req_i[3] && rfsh_win_i)                 p = 3;
      end
      if (p >= 0) begin
        m_port = p;
        m_we   = we_i[p];
        m_addr = addr_i[p*AW +: AW];
        m_din  = wdata_i[p*8 +: 8];
        m_t    = 1;
      end
    end else if (m_t <= ACC) begin
      if (m_t == ACC && !m_we) m_rdata = sd_dout_i;
      m_t = m_t + 1;
    end else begin
      m_t = 0;
    end
  end

  always @(negedge clk_i) begin
    logic        acc;
    logic [3:0]  exp_ack;
    acc     = (m_t >= 1) && (m_t <= ACC);
    exp_ack = (m_t == ACC + 1) ? (4'b0001 << m_port) : 4'b0000;
    check("busy",    32'(busy_o),    32'(m_t != 0));
    check("sd_we",   32'(sd_we_o),   32'(acc && m_we));
    check("sd_rd",   32'(sd_rd_o),   32'(acc && !m_we));
    check("ack",     32'(ack_o),     32'(exp_ack));
    check("grant",   32'(grant_o),   32'(m_port));
    check("sd_addr", 32'(sd_addr_o), 32'(m_addr));
    check("sd_din",  32'(sd_din_o),  32'(m_din));
    check("rdata",   32'(rdata_o),   32'(m_rdata));
  end

  bit rand_dout = 1'b1;
  initial begin
    forever begin
      @(negedge clk_i);
      if (rand_dout) sd_dout_i = 8'($urandom);
    end
  end

  int ack_q[$];

  task automatic collect_acks(input int n, input bit drop);
    int k = 0;
    ack_q.delete();
    for (int i = 0; i < 400 && k < n; i++) begin
      @(negedge clk_i);
      if (ack_o != 4'b0000) begin
        check("ack_onehot", 32'($countones(ack_o)), 32'd1);
        for (int p = 0; p < 4; p++) if (ack_o[p]) ack_q.push_back(p);
        k++;
        if (drop) req_i = req_i & ~ack_o;
      end
    end
    check("acks_seen", 32'(k), 32'(n));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, cnt;
    bit got;
    reset_n_i = 0; req_i = 0; we_i = 0; addr_i = '0; wdata_i = '0;
    rfsh_win_i = 0; sd_ready_i = 1; sd_dout_i = 8'h00;
    repeat (2) @(negedge clk_i);
    check("rst_busy",  32'(busy_o),  32'd0);
    check("rst_rdata", 32'(rdata_o), 32'd0);
    reset_n_i = 1;
    @(negedge clk_i);

    // Single CPU write
    req_i = 4'b0100; we_i = 4'b0100;
    addr_i[2*AW +: AW] = 23'h00123; wdata_i[23:16] = 8'h5A;
    cyc = 0; cnt = 0; got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk_i);
      cyc++;
      if (cyc == 1) req_i = 4'b0000;
      if (sd_we_o) cnt++;
      if (ack_o != 4'b0000) got = 1;
    end
    check("wr_latency", 32'(cyc), 32'(ACC + 1));
    check("wr_strobes", 32'(cnt), 32'(ACC));
    check("wr_ack",     32'(ack_o), 32'h4);
    check("wr_addr",    32'(sd_addr_o), 32'h00123);
    check("wr_din",     32'(sd_din_o), 32'h5A);
    repeat (3) @(negedge clk_i);
    check("wr_addr_hold", 32'(sd_addr_o), 32'h00123);

    // Priority, all four in the same cycle
    rfsh_win_i = 1; we_i = 4'b0000;
    addr_i = {23'h300003, 23'h200002, 23'h100001, 23'h000004};
    req_i = 4'b1111;
    collect_acks(4, 1);
    for (int i = 0; i < 4; i++) check("prio_order", 32'(ack_q[i]), 32'(i));

    // Cassette gating outside refresh window
    rfsh_win_i = 0; req_i = 4'b1000; cnt = 0;
    repeat (20) begin @(negedge clk_i); if (busy_o) cnt++; end
    check("gate_busy", 32'(cnt), 32'd0);

    // Fairness: port 2 continuous, port 3 in window
    rfsh_win_i = 1; req_i = 4'b1100;
    collect_acks(3, 0);
    req_i = 4'b0000;
    check("fair_0", 32'(ack_q[0]), 32'd2);
    check("fair_1", 32'(ack_q[1]), 32'd3);
    check("fair_2", 32'(ack_q[2]), 32'd2);
    repeat (3) @(negedge clk_i);

    // Port 3 read, data sampled only on the last access cycle
    rand_dout = 0; sd_dout_i = 8'h3C;
    we_i = 4'b0000; addr_i[3*AW +: AW] = 23'h600000; req_i = 4'b1000;
    cyc = 0; got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk_i);
      cyc++;
      if (cyc == 1) req_i = 4'b0000;
      if (ack_o != 4'b0000) got = 1;
      else if (cyc == ACC) sd_dout_i = 8'hC3;
      else sd_dout_i = 8'h3C;
    end
    check("rd_ack",   32'(ack_o),   32'h8);
    check("rd_data",  32'(rdata_o), 32'hC3);
    check("rd_addr",  32'(sd_addr_o), 32'h600000);
    rand_dout = 1;
    we_i = 4'b0001; wdata_i[7:0] = 8'h77; req_i = 4'b0001;
    collect_acks(1, 1);
    check("rd_hold",  32'(rdata_o), 32'hC3);
    repeat (2) @(negedge clk_i);

    // Reset in ACCESS cycle 4
    we_i = 4'b0000; addr_i[AW +: AW] = 23'h055555; req_i = 4'b0010;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_i);
      if (c == 1) req_i = 4'b0000;
    end
    check("rst_rd_before", 32'(sd_rd_o), 32'd1);
    #2 reset_n_i = 0;
    #1;
    check("rst_rd_async", 32'(sd_rd_o), 32'd0);
    check("rst_busy_async", 32'(busy_o), 32'd0);
    check("rst_addr", 32'(sd_addr_o), 32'd0);
    @(negedge clk_i);
    reset_n_i = 1;
    cnt = 0;
    repeat (20) begin @(negedge clk_i); if (ack_o != 4'b0000) cnt++; end
    check("rst_no_ack", 32'(cnt), 32'd0);
    req_i = 4'b0010;
    collect_acks(1, 1);
    check("rst_regrant", 32'(ack_q[0]), 32'd1);

    // sd_ready gating, and completion while sd_ready drops
    sd_ready_i = 0; we_i = 4'b0001; wdata_i[7:0] = 8'hA5; req_i = 4'b0001; cnt = 0;
    repeat (10) begin @(negedge clk_i); if (sd_we_o || sd_rd_o || busy_o) cnt++; end
    check("rdy_nostrobe", 32'(cnt), 32'd0);
    sd_ready_i = 1;
    @(negedge clk_i);
    check("rdy_grant", 32'(busy_o), 32'd1);
    check("rdy_we",    32'(sd_we_o), 32'd1);
    req_i = 4'b0000; sd_ready_i = 0;
    collect_acks(1, 0);
    check("rdy_complete", 32'(ack_q[0]), 32'd0);
    sd_ready_i = 1;
    repeat (3) @(negedge clk_i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/svi_sdram_arbiter.md
SVI_SDRAM_ARBITER -- requirements
Module: svi_sdram_arbiter

Interface
REQ-001 SHALL have parameter ACC_CYCLES, default 8: number of cycles one SDRAM access is held, range 2..255.
REQ-002 SHALL have parameter AW, default 23: SDRAM byte-address width.
REQ-003 SHALL have port clk_i, in, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n_i, in, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port req_i, in, 4: request per port; 0=ROM/cart download, 1=hard-reset cleanup, 2=CPU RAM, 3=cassette reader.
REQ-006 SHALL have port we_i, in, 4: per-port write (1) or read (0) qualifier.
REQ-007 SHALL have port addr_i, in, 4*AW: packed per-port address, port n at bits [n*AW +: AW].
REQ-008 SHALL have port wdata_i, in, 32: packed per-port write byte, port n at bits [n*8 +: 8].
REQ-009 SHALL have port rfsh_win_i, in, 1: high while the CPU is in a refresh cycle; gates port 3.
REQ-010 SHALL have port ack_o, out, 4: one-cycle completion pulse per port.
REQ-011 SHALL have port rdata_o, out, 8: read data, valid in the ack cycle, held until the next ack.
REQ-012 SHALL have port busy_o, out, 1: access in progress.
REQ-013 SHALL have port grant_o, out, 2: index of the port currently or last served.
REQ-014 SHALL have port sd_ready_i, in, 1: SDRAM controller initialised.
REQ-015 SHALL have port sd_addr_o, out, AW: SDRAM address.
REQ-016 SHALL have port sd_din_o, out, 8: SDRAM write data.
REQ-017 SHALL have port sd_we_o, out, 1: SDRAM write strobe.
REQ-018 SHALL have port sd_rd_o, out, 1: SDRAM read strobe.
REQ-019 SHALL have port sd_dout_i, in, 8: SDRAM read data.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS, ACK.
REQ-021 SHALL leave IDLE only when sd_ready_i=1 and at least one port is eligible; SHALL then go to ACCESS on the next edge.
REQ-022 SHALL treat ports 0..2 as eligible when req_i[n]=1.
REQ-023 SHALL treat port 3 as eligible only when req_i[3]=1 and rfsh_win_i=1, both sampled in the grant cycle.
REQ-024 SHALL use fixed priority 0>1>2>3, with one exception: after a port-2 grant, an eligible port 3 SHALL win the next grant over port 2, but not over port 0 or 1.
REQ-025 SHALL, on grant, latch the port index, we, address and write byte into internal registers; later changes on the inputs SHALL NOT affect the access in flight.
REQ-026 SHALL, in ACCESS, drive sd_addr_o and sd_din_o from the latched values and hold sd_we_o or sd_rd_o high for exactly ACC_CYCLES cycles, using a down-counter loaded with ACC_CYCLES-1.
REQ-027 SHALL, for reads, capture sd_dout_i into rdata_o on the last ACCESS cycle (counter=0).
REQ-028 SHALL go from ACCESS to ACK when the counter reaches 0, then spend exactly one cycle in ACK.
REQ-029 SHALL assert ack_o[granted] for the single ACK cycle, then return to IDLE.
REQ-030 SHALL give a grant-to-ack latency of ACC_CYCLES+1 cycles, and a minimum of 2 idle-to-grant cycles between back-to-back accesses.
REQ-031 SHALL hold sd_we_o and sd_rd_o low outside ACCESS; both SHALL never be high together.
REQ-032 SHALL keep sd_addr_o and sd_din_o at their last values outside ACCESS.
REQ-033 SHALL treat a request withdrawn before grant as not served.
REQ-034 SHALL complete an access already granted even if its req_i drops, and SHALL still pulse ack_o.
REQ-035 SHALL NOT abort an access when rfsh_win_i falls during a port-3 access.
REQ-036 SHALL NOT start a new grant while sd_ready_i=0, but SHALL complete an access already in progress.
REQ-037 SHALL drive busy_o=1 in ACCESS and ACK states, and 0 in IDLE.

Reset
REQ-038 SHALL, on reset_n_i=0, immediately force state IDLE and drive all outputs to zero, including rdata_o, grant_o, sd_addr_o and sd_din_o, abandoning any access in flight.
REQ-039 SHALL NOT pulse ack_o for an access abandoned by reset.
REQ-040 SHALL, after release of reset_n_i, wait for the first rising edge before any grant.

Verification
REQ-041 Single CPU write: req_i=0100, we_i[2]=1, addr 0x00123, data 0x5A, ACC_CYCLES=8 -> sd_we_o high for 8 cycles with those values; ack_o=0100 on cycle 9 after grant.
REQ-042 Priority: req_i=1111 all in the same cycle, rfsh_win_i=1 -> grant order 0,1,2,3; each port gets one ack; no overlap of strobes.
REQ-043 Cassette gating and fairness: req_i[3]=1 with rfsh_win_i=0 -> no grant; port 2 requesting continuously and rfsh_win_i=1 -> grants alternate 2,3,2.
REQ-044 Read data: port 3 read of 0x600000 with sd_dout_i=0xC3 on the last ACCESS cycle -> rdata_o=0xC3 with ack_o=1000; value held through a following write.
REQ-045 Reset mid-access: reset_n_i pulsed low in ACCESS cycle 4 -> sd_rd_o drops asynchronously; no ack_o; next grant is re-arbitrated from IDLE.
REQ-046 sd_ready_i=0 with req_i=0001 -> no strobe; raising sd_ready_i -> grant within 1 cycle.
